// File: rtl/switch_ring_arbiter.sv
// Ring-link tile controller: ring-priority output arbitration with a PE starvation boost,
// plus a 2-deep delivery FIFO for flits addressed to this tile. Output latency 1 cycle.
module switch_ring_arbiter #(
    parameter logic [1:0] RANK         = 2'd0,
    parameter int         STARVE_LIMIT = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] ring_in_data,
    input  logic       ring_in_valid,
    output logic       ring_in_ready,
    input  logic [7:0] pe_tx_data,
    input  logic       pe_tx_valid,
    output logic       pe_tx_ready,
    output logic [7:0] ring_out_data,
    output logic       ring_out_valid,
    input  logic       ring_out_ready,
    output logic [7:0] pe_rx_data,
    output logic       pe_rx_valid,
    input  logic       pe_rx_ready,
    output logic       pe_boost
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic       local_flit;
    logic       pass_flit;
    logic       can_load;
    logic       grant_ring;
    logic       grant_pe;
    logic       push;
    logic       pop;
    logic [3:0] starve_cnt;

    logic [7:0] mem [2];
    logic       wr_ptr;
    logic       rd_ptr;
    logic [1:0] count;

    assign local_flit = ring_in_valid && (ring_in_data[5:4] == RANK);
    assign pass_flit  = ring_in_valid && !local_flit;
    assign can_load   = !ring_out_valid || ring_out_ready;

    // Ring wins conflicts until the PE has waited LIMIT cycles; grants are suppressed in reset.
    assign grant_ring = !rst && can_load && pass_flit &&
                        (!pe_tx_valid || (starve_cnt < LIMIT));
    assign grant_pe   = !rst && can_load && pe_tx_valid &&
                        (!pass_flit || (starve_cnt >= LIMIT));

    assign ring_in_ready = !rst && (local_flit ? (count < 2'd2) : grant_ring);
    assign pe_tx_ready   = grant_pe;

    assign push        = local_flit && ring_in_ready;
    assign pop         = !rst && pe_rx_valid && pe_rx_ready;
    assign pe_rx_valid = (count != 2'd0);
    assign pe_rx_data  = pe_rx_valid ? mem[rd_ptr] : 8'h00;

    always_ff @(posedge clk) begin
        if (rst) begin
            ring_out_valid <= 1'b0;
            ring_out_data  <= 8'h00;
            pe_boost       <= 1'b0;
            starve_cnt     <= 4'd0;
        end else begin
            pe_boost <= grant_pe && pass_flit;
            if (grant_ring) begin
                ring_out_data  <= ring_in_data;
                ring_out_valid <= 1'b1;
            end else if (grant_pe) begin
                ring_out_data  <= pe_tx_data;
                ring_out_valid <= 1'b1;
            end else if (ring_out_ready) begin
                ring_out_valid <= 1'b0;
            end

            if (grant_pe || !pe_tx_valid) begin
                starve_cnt <= 4'd0;
            end else if (starve_cnt != 4'd15) begin
                starve_cnt <= starve_cnt + 4'd1;
            end
        end
    end

    // Push readiness uses only the registered count, so a full FIFO refuses even during a pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= ring_in_data;
                wr_ptr      <= !wr_ptr;
            end
            if (pop) begin
                rd_ptr <= !rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_switch_ring_arbiter.sv
// Directed bench for switch_ring_arbiter with RANK=1, STARVE_LIMIT=3.
module tb_switch_ring_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] ring_in_data;
    logic       ring_in_valid;
    logic       ring_in_ready;
    logic [7:0] pe_tx_data;
    logic       pe_tx_valid;
    logic       pe_tx_ready;
    logic [7:0] ring_out_data;
    logic       ring_out_valid;
    logic       ring_out_ready;
    logic [7:0] pe_rx_data;
    logic       pe_rx_valid;
    logic       pe_rx_ready;
    logic       pe_boost;

    int errors = 0;
    int checks = 0;

    switch_ring_arbiter #(.RANK(2'd1), .STARVE_LIMIT(3)) dut (
        .clk(clk), .rst(rst),
        .ring_in_data(ring_in_data), .ring_in_valid(ring_in_valid), .ring_in_ready(ring_in_ready),
        .pe_tx_data(pe_tx_data), .pe_tx_valid(pe_tx_valid), .pe_tx_ready(pe_tx_ready),
        .ring_out_data(ring_out_data), .ring_out_valid(ring_out_valid), .ring_out_ready(ring_out_ready),
        .pe_rx_data(pe_rx_data), .pe_rx_valid(pe_rx_valid), .pe_rx_ready(pe_rx_ready),
        .pe_boost(pe_boost)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ring_in_data = 8'h25; ring_in_valid = 1'b1;
        pe_tx_data = 8'hF4; pe_tx_valid = 1'b1;
        ring_out_ready = 1'b1; pe_rx_ready = 1'b1;
        tick(); tick();
        checks++; if (ring_in_ready !== 1'b0) begin errors++; $display("FAIL reset_ring_in_ready got=%b exp=0", ring_in_ready); end
        checks++; if (pe_tx_ready !== 1'b0) begin errors++; $display("FAIL reset_pe_tx_ready got=%b exp=0", pe_tx_ready); end
        checks++; if (ring_out_valid !== 1'b0 || ring_out_data !== 8'h00) begin errors++; $display("FAIL reset_ring_out got=%b/%h exp=0/00", ring_out_valid, ring_out_data); end
        checks++; if (pe_rx_valid !== 1'b0 || pe_rx_data !== 8'h00) begin errors++; $display("FAIL reset_pe_rx got=%b/%h exp=0/00", pe_rx_valid, pe_rx_data); end
        checks++; if (pe_boost !== 1'b0) begin errors++; $display("FAIL reset_pe_boost got=%b exp=0", pe_boost); end
        ring_in_valid = 1'b0; pe_tx_valid = 1'b0; pe_rx_ready = 1'b0;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_pass();
        ring_in_data = 8'h25; ring_in_valid = 1'b1; ring_out_ready = 1'b1;
        #1;
        checks++; if (ring_in_ready !== 1'b1) begin errors++; $display("FAIL pass_ready got=%b exp=1", ring_in_ready); end
        tick();
        ring_in_valid = 1'b0;
        checks++; if (ring_out_valid !== 1'b1 || ring_out_data !== 8'h25) begin errors++; $display("FAIL pass_out got=%b/%h exp=1/25", ring_out_valid, ring_out_data); end
        checks++; if (pe_rx_valid !== 1'b0) begin errors++; $display("FAIL pass_not_local got=%b exp=0", pe_rx_valid); end
        tick();
        checks++; if (ring_out_valid !== 1'b0) begin errors++; $display("FAIL pass_drain got=%b exp=0", ring_out_valid); end
    endtask

    task automatic test_fifo();
        logic [7:0] locals [2];
        locals[0] = 8'h15; locals[1] = 8'h17;
        pe_rx_ready = 1'b0; ring_out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            ring_in_data = locals[i]; ring_in_valid = 1'b1;
            #1;
            checks++; if (ring_in_ready !== 1'b1) begin errors++; $display("FAIL fifo_push%0d got=%b exp=1", i, ring_in_ready); end
            tick();
        end
        checks++; if (ring_out_valid !== 1'b0) begin errors++; $display("FAIL fifo_local_not_forwarded got=%b exp=0", ring_out_valid); end
        ring_in_data = 8'h1A;
        #1;
        checks++; if (ring_in_ready !== 1'b0) begin errors++; $display("FAIL fifo_full_refuse got=%b exp=0", ring_in_ready); end
        checks++; if (pe_rx_valid !== 1'b1 || pe_rx_data !== 8'h15) begin errors++; $display("FAIL fifo_head0 got=%b/%h exp=1/15", pe_rx_valid, pe_rx_data); end
        ring_in_data = 8'h25;
        #1;
        checks++; if (ring_in_ready !== 1'b1) begin errors++; $display("FAIL fifo_full_pass_ok got=%b exp=1", ring_in_ready); end
        tick();
        checks++; if (ring_out_data !== 8'h25) begin errors++; $display("FAIL fifo_full_pass_out got=%h exp=25", ring_out_data); end
        ring_in_data = 8'h1A; pe_rx_ready = 1'b1;
        #1;
        checks++; if (ring_in_ready !== 1'b0) begin errors++; $display("FAIL fifo_full_pop_refuse got=%b exp=0", ring_in_ready); end
        tick();
        checks++; if (pe_rx_data !== 8'h17) begin errors++; $display("FAIL fifo_head1 got=%h exp=17", pe_rx_data); end
        checks++; if (ring_in_ready !== 1'b1) begin errors++; $display("FAIL fifo_push_pop_ready got=%b exp=1", ring_in_ready); end
        tick();
        ring_in_valid = 1'b0;
        checks++; if (pe_rx_valid !== 1'b1 || pe_rx_data !== 8'h1A) begin errors++; $display("FAIL fifo_head2 got=%b/%h exp=1/1a", pe_rx_valid, pe_rx_data); end
        tick();
        pe_rx_ready = 1'b0;
        checks++; if (pe_rx_valid !== 1'b0) begin errors++; $display("FAIL fifo_empty got=%b exp=0", pe_rx_valid); end
    endtask

    task automatic test_starve();
        logic [7:0] exp_out [6];
        logic [5:0] exp_pe;
        int idx;
        exp_out[0] = 8'h20; exp_out[1] = 8'h21; exp_out[2] = 8'h22;
        exp_out[3] = 8'hF4; exp_out[4] = 8'h23; exp_out[5] = 8'h24;
        exp_pe = 6'b001000;
        idx = 0;
        ring_out_ready = 1'b1; pe_tx_data = 8'hF4; pe_tx_valid = 1'b1; ring_in_valid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            ring_in_data = 8'h20 + 8'(idx);
            #1;
            checks++; if (pe_tx_ready !== exp_pe[k] || ring_in_ready !== !exp_pe[k]) begin errors++; $display("FAIL starve_grant%0d got pe=%b ring=%b exp pe=%b", k, pe_tx_ready, ring_in_ready, exp_pe[k]); end
            if (ring_in_ready) idx++;
            tick();
            checks++; if (ring_out_data !== exp_out[k]) begin errors++; $display("FAIL starve_out%0d got=%h exp=%h", k, ring_out_data, exp_out[k]); end
            checks++; if (pe_boost !== exp_pe[k]) begin errors++; $display("FAIL starve_boost%0d got=%b exp=%b", k, pe_boost, exp_pe[k]); end
        end
        pe_tx_valid = 1'b0; ring_in_valid = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        ring_in_data = 8'h30; ring_in_valid = 1'b1; ring_out_ready = 1'b1;
        tick();
        ring_out_ready = 1'b0; ring_in_data = 8'h31; pe_tx_valid = 1'b1;
        #1;
        checks++; if (ring_in_ready !== 1'b0 || pe_tx_ready !== 1'b0) begin errors++; $display("FAIL stall_readies got ring=%b pe=%b exp 0/0", ring_in_ready, pe_tx_ready); end
        tick();
        pe_tx_valid = 1'b0;
        tick();
        checks++; if (ring_out_valid !== 1'b1 || ring_out_data !== 8'h30) begin errors++; $display("FAIL stall_hold got=%b/%h exp=1/30", ring_out_valid, ring_out_data); end
        ring_out_ready = 1'b1;
        #1;
        checks++; if (ring_in_ready !== 1'b1) begin errors++; $display("FAIL release_ready got=%b exp=1", ring_in_ready); end
        tick();
        checks++; if (ring_out_valid !== 1'b1 || ring_out_data !== 8'h31) begin errors++; $display("FAIL b2b_first got=%b/%h exp=1/31", ring_out_valid, ring_out_data); end
        ring_in_data = 8'h32;
        tick();
        ring_in_valid = 1'b0;
        checks++; if (ring_out_valid !== 1'b1 || ring_out_data !== 8'h32) begin errors++; $display("FAIL b2b_second got=%b/%h exp=1/32", ring_out_valid, ring_out_data); end
    endtask

    task automatic test_simultaneous();
        ring_in_data = 8'h1C; ring_in_valid = 1'b1;
        pe_tx_data = 8'hF9; pe_tx_valid = 1'b1; ring_out_ready = 1'b1; pe_rx_ready = 1'b0;
        #1;
        checks++; if (ring_in_ready !== 1'b1 || pe_tx_ready !== 1'b1) begin errors++; $display("FAIL simul_ready got ring=%b pe=%b exp 1/1", ring_in_ready, pe_tx_ready); end
        tick();
        ring_in_valid = 1'b0; pe_tx_valid = 1'b0;
        checks++; if (ring_out_valid !== 1'b1 || ring_out_data !== 8'hF9) begin errors++; $display("FAIL simul_out got=%b/%h exp=1/f9", ring_out_valid, ring_out_data); end
        checks++; if (pe_rx_valid !== 1'b1 || pe_rx_data !== 8'h1C) begin errors++; $display("FAIL simul_rx got=%b/%h exp=1/1c", pe_rx_valid, pe_rx_data); end
        checks++; if (pe_boost !== 1'b0) begin errors++; $display("FAIL simul_boost got=%b exp=0", pe_boost); end
    endtask

    task automatic test_reset_mid();
        logic [3:0] exp_pe;
        exp_pe = 4'b1000;
        // FIFO holds 0x1C; add 0x15 while the output is stalled and the PE is blocked.
        ring_out_ready = 1'b0; ring_in_data = 8'h15; ring_in_valid = 1'b1;
        pe_tx_data = 8'hF4; pe_tx_valid = 1'b1;
        tick();
        ring_in_data = 8'h25;
        tick();
        checks++; if (ring_out_valid !== 1'b1 || pe_rx_valid !== 1'b1) begin errors++; $display("FAIL premid_state got out=%b rx=%b exp 1/1", ring_out_valid, pe_rx_valid); end
        rst = 1'b1; ring_out_ready = 1'b1;
        #1;
        checks++; if (ring_in_ready !== 1'b0 || pe_tx_ready !== 1'b0) begin errors++; $display("FAIL midrst_readies got ring=%b pe=%b exp 0/0", ring_in_ready, pe_tx_ready); end
        tick();
        rst = 1'b0;
        checks++; if (ring_out_valid !== 1'b0 || ring_out_data !== 8'h00) begin errors++; $display("FAIL midrst_out got=%b/%h exp=0/00", ring_out_valid, ring_out_data); end
        checks++; if (pe_rx_valid !== 1'b0 || pe_rx_data !== 8'h00) begin errors++; $display("FAIL midrst_fifo got=%b/%h exp=0/00", pe_rx_valid, pe_rx_data); end
        // A cleared starve counter lets the ring win exactly three conflicts again.
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++; if (pe_tx_ready !== exp_pe[k]) begin errors++; $display("FAIL midrst_starve%0d got=%b exp=%b", k, pe_tx_ready, exp_pe[k]); end
            tick();
        end
        ring_in_valid = 1'b0; pe_tx_valid = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_pass();
        test_fifo();
        test_starve();
        test_back_to_back();
        test_simultaneous();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
